// File: rtl/ccg_truth_sweep.sv
// Exhaustive truth-table sweeper: drives stim 0..2^NUM_IN-1 into a CUT and folds resp into a MISR signature.
// Define CCG_ONES_COUNT_EN to build the per-output ones counters and the o_ones_cnt port.
module ccg_truth_sweep #(
    parameter int                NUM_IN    = 7,
    parameter int                NUM_OUT   = 7,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h002D,
    parameter logic [MISR_W-1:0] MISR_SEED = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic [NUM_IN-1:0]  o_stim,
    input  logic [NUM_OUT-1:0] i_resp,
    output logic               o_busy,
    output logic               o_done,
    output logic [MISR_W-1:0]  o_signature
`ifdef CCG_ONES_COUNT_EN
    ,
    output logic [NUM_OUT*(NUM_IN+1)-1:0] o_ones_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [NUM_IN-1:0] STIM_LAST = '1;

    logic [1:0]        r_state;
    logic [NUM_IN-1:0] r_stim;
    logic [MISR_W-1:0] r_sig;

    logic              w_accept;
    logic              w_sample;
    logic [MISR_W-1:0] w_sig_next;

    assign w_accept = (r_state == S_IDLE) && i_start;
    // abort beats the final vector, so a cancelled cycle never samples resp.
    assign w_sample = (r_state == S_SWEEP) && !i_abort;

    assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0}
                      ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                      ^ MISR_W'(i_resp);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_stim  <= '0;
            r_sig   <= MISR_SEED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_SWEEP;
                        r_stim  <= '0;
                        r_sig   <= MISR_SEED;
                    end
                end
                S_SWEEP: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sig <= w_sig_next;
                        if (r_stim == STIM_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_stim <= r_stim + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CCG_ONES_COUNT_EN
    localparam int CNT_W = NUM_IN + 1;

    logic [NUM_OUT*CNT_W-1:0] r_ones_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_ones_cnt <= '0;
        end else if (w_sample) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_ones_cnt[k*CNT_W +: CNT_W] <= r_ones_cnt[k*CNT_W +: CNT_W] + CNT_W'(i_resp[k]);
            end
        end
    end

    assign o_ones_cnt = r_ones_cnt;
`endif

    assign o_stim      = r_stim;
    assign o_signature = r_sig;
    assign o_busy      = (r_state == S_SWEEP);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: doc/ccg_truth_sweep.md
# ccg_truth_sweep

Parametrised exhaustive truth-table sweeper for generated combinational benchmark circuits. It drives every input vector 0..2^NUM_IN-1 into an attached circuit under test (CUT), one vector per clock. It compresses the CUT responses into a MISR signature used to label circuits in the dataset. It sits between the dataset build controller and any generated NUM_IN-input / NUM_OUT-output CUT netlist.

## Interface
- NUM_IN, 7, CUT input count (1..16)
- NUM_OUT, 7, CUT output count (1..MISR_W)
- MISR_W, 16, signature width (>= 2)
- MISR_POLY, 16'h002D, feedback polynomial, MISR_W bits
- MISR_SEED, 0, signature value loaded on start
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; honoured only in IDLE
- abort  input  1  cancel sweep; honoured only in SWEEP
- stim  output  NUM_IN  registered vector driven to CUT
- resp  input  NUM_OUT  CUT outputs, combinational function of stim
- busy  output  1  high in SWEEP
- done  output  1  one-cycle pulse at sweep completion
- signature  output  MISR_W  final MISR value, held until next start
- ones_cnt  output  NUM_OUT*(NUM_IN+1)  per-output count of 1 responses; present only with CCG_ONES_COUNT_EN; output k occupies bits [k*(NUM_IN+1) +: NUM_IN+1]

## Operation
- Reset values: state IDLE, stim 0, busy 0, done 0, signature MISR_SEED, ones_cnt 0.
- States: IDLE, SWEEP, DONE.
- IDLE: start=1 -> SWEEP, stim<=0, signature<=MISR_SEED, ones_cnt<=0.
- SWEEP: every cycle sample resp for current stim.
  - signature <= {signature[MISR_W-2:0],1'b0} ^ (signature[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended resp.
  - ones_cnt[k] += resp[k].
  - stim < 2^NUM_IN-1: stim <= stim+1.
  - stim == 2^NUM_IN-1: -> DONE; stim holds (no wrap).
- DONE: done=1 for exactly this cycle -> IDLE unconditionally. start in the DONE cycle is ignored.
- start while in SWEEP or DONE: ignored.
- abort in SWEEP: -> IDLE next cycle, no done pulse. signature/ones_cnt keep partial values and are invalid. abort and final vector in the same cycle: abort wins.
- rst at any time, including mid-sweep: all state to reset values next edge. rst has priority over start/abort.
- Counters wide enough: ones_cnt saturation impossible (max 2^NUM_IN fits NUM_IN+1 bits). stim counter NUM_IN bits plus terminal compare; no overflow.

## Timing
- start sampled at edge 0. SWEEP occupies cycles 1..2^NUM_IN with stim = 0..2^NUM_IN-1. done high in cycle 2^NUM_IN+1. Total latency start -> done = 2^NUM_IN+1 cycles.
- resp is sampled at the same edge that advances stim. The CUT path stim -> resp is single-cycle combinational.
- signature and ones_cnt are stable and valid from the done cycle until the cycle after the next accepted start.
- busy is high exactly during SWEEP cycles. Back-to-back: earliest next accepted start is in cycle 2^NUM_IN+2 (IDLE).

## Configuration
- CCG_ONES_COUNT_EN defined: ones_cnt port and NUM_OUT counters of NUM_IN+1 bits are built, updated as above.
- Undefined: ones_cnt port and counters absent. Signature, stim and handshake behaviour are identical.

## Test plan
Bench parameters: NUM_IN=2, NUM_OUT=1, MISR_W=4, MISR_POLY=4'h3, MISR_SEED=0, CCG_ONES_COUNT_EN defined.
- CUT resp=stim[0]^stim[1], start pulse at cycle 0 -> stim 0,1,2,3 in cycles 1-4; done in cycle 5; signature=4'h6; ones_cnt=3'd2; busy high cycles 1-4 only.
- resp tied 1 -> signature=4'hF, ones_cnt=3'd4. resp tied 0 -> signature=4'h0, ones_cnt=0.
- abort at cycle 2 -> IDLE at cycle 3; no done ever; busy low from cycle 3. New start then gives signature 4'h6 (XOR CUT).
- rst at cycle 3 mid-sweep -> stim=0, busy=0, signature=0, ones_cnt=0 next cycle; no done.
- start held high continuously -> done pulses every 6 cycles (cycles 5, 11, ...); start during SWEEP does not restart stim.
- Default parameters (NUM_IN=7): done exactly 129 cycles after start; stim reaches 127 and never wraps to 0 before done.
